// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the record-path receiver and the playback transmitter.
package i2s_pkg;

  localparam int SAMPLE_WIDTH = 24;
  localparam int FRAME_WIDTH  = 2 * SAMPLE_WIDTH;
  localparam int CNT_WIDTH    = 6;
  localparam bit LEFT_IS_LRCLK_LOW = 1'b1;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    LEFT      = 2'd1,
    RIGHT     = 2'd2
  } rx_state_t;

  // A word cut short by an early lrclk edge keeps its MSB at the top; missing LSBs read as zero.
  function automatic logic [SAMPLE_WIDTH-1:0] left_justify(
    input logic [SAMPLE_WIDTH-1:0] data,
    input logic [CNT_WIDTH-1:0]    nbits
  );
    logic [CNT_WIDTH-1:0] pad;
    pad = CNT_WIDTH'(SAMPLE_WIDTH) - nbits;
    return data << pad;
  endfunction

endpackage

// File: rtl/i2s_receiver_if.sv
// Codec pins plus the frame valid/ready stream of the I2S receiver.
interface i2s_receiver_if;
  import i2s_pkg::*;

  logic                   i2s_bclk;
  logic                   i2s_lrclk;
  logic                   i2s_sdata;
  logic [FRAME_WIDTH-1:0] frame_out;
  logic                   frame_valid;
  logic                   frame_ready;
  logic                   overrun;
  logic                   locked;

  modport master (
    input  i2s_bclk, i2s_lrclk, i2s_sdata, frame_ready,
    output frame_out, frame_valid, overrun, locked
  );

  modport slave (
    output i2s_bclk, i2s_lrclk, i2s_sdata, frame_ready,
    input  frame_out, frame_valid, overrun, locked
  );

endinterface

// File: rtl/i2s_edge_sync.sv
// Two-flop synchroniser followed by one edge flop; every instance has the same depth so
// data stays aligned with the bit clock it was launched against.
module i2s_edge_sync (
  input  logic ac_mclk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sync_r;

  // shift the asynchronous pin through the synchroniser and edge flop
  always_ff @(posedge ac_mclk or posedge reset) begin
    if (reset) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], din};
    end
  end

  assign level = sync_r[1];
  assign rise  = sync_r[1] & ~sync_r[2];
  assign fall  = ~sync_r[1] & sync_r[2];

endmodule

// File: rtl/i2s_receiver.sv
// I2S record-path receiver: oversamples the codec serial port in the ac_mclk domain and
// delivers {left,right} frames on a valid/ready stream with lock and overrun reporting.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int LRDEL         = 1,
  parameter int LRCLK_TIMEOUT = 1024
) (
  input logic            ac_mclk,
  input logic            reset,
  i2s_receiver_if.master bus
);

  localparam int TMO_WIDTH = $clog2(LRCLK_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] FIRST_BIT = CNT_WIDTH'(LRDEL);
  localparam logic [CNT_WIDTH-1:0] END_BIT   = CNT_WIDTH'(LRDEL + SAMPLE_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [TMO_WIDTH-1:0] TMO_LAST  = TMO_WIDTH'(LRCLK_TIMEOUT - 1);

  logic bclk_rise_s, bclk_level_unused_s, bclk_fall_unused_s;
  logic lr_rise_s, lr_fall_s, lr_level_unused_s;
  logic sdata_s, sdata_rise_unused_s, sdata_fall_unused_s;

  logic                    lr_edge_s, left_start_s, right_start_s;
  logic                    shift_en_s, timeout_s;
  logic [CNT_WIDTH-1:0]    bits_taken_s;
  logic [SAMPLE_WIDTH-1:0] word_s;

  logic [CNT_WIDTH-1:0]    bit_cnt_r;
  logic [SAMPLE_WIDTH-1:0] shreg_r;
  logic [SAMPLE_WIDTH-1:0] left_hold_r;
  logic [TMO_WIDTH-1:0]    tmo_cnt_r;
  rx_state_t               state_r;
  logic [FRAME_WIDTH-1:0]  frame_out_r;
  logic                    frame_valid_r, overrun_r, locked_r;

  i2s_edge_sync u_bclk_sync (
    .ac_mclk (ac_mclk), .reset (reset), .din (bus.i2s_bclk),
    .level (bclk_level_unused_s), .rise (bclk_rise_s), .fall (bclk_fall_unused_s)
  );

  i2s_edge_sync u_lrclk_sync (
    .ac_mclk (ac_mclk), .reset (reset), .din (bus.i2s_lrclk),
    .level (lr_level_unused_s), .rise (lr_rise_s), .fall (lr_fall_s)
  );

  i2s_edge_sync u_sdata_sync (
    .ac_mclk (ac_mclk), .reset (reset), .din (bus.i2s_sdata),
    .level (sdata_s), .rise (sdata_rise_unused_s), .fall (sdata_fall_unused_s)
  );

  // word boundaries, capture window, justified word and timeout decode
  always_comb begin
    lr_edge_s = lr_rise_s | lr_fall_s;
    if (LEFT_IS_LRCLK_LOW) begin
      left_start_s  = lr_fall_s;
      right_start_s = lr_rise_s;
    end else begin
      left_start_s  = lr_rise_s;
      right_start_s = lr_fall_s;
    end
    shift_en_s = bclk_rise_s && (bit_cnt_r >= FIRST_BIT) && (bit_cnt_r < END_BIT);
    if (bit_cnt_r < FIRST_BIT) begin
      bits_taken_s = CNT_WIDTH'(0);
    end else if (bit_cnt_r >= END_BIT) begin
      bits_taken_s = CNT_WIDTH'(SAMPLE_WIDTH);
    end else begin
      bits_taken_s = bit_cnt_r - FIRST_BIT;
    end
    word_s    = left_justify(shreg_r, bits_taken_s);
    // an lrclk edge in the final cycle still counts as activity
    timeout_s = (state_r != WAIT_SYNC) && (tmo_cnt_r == TMO_LAST) && !lr_edge_s;
  end

  // bit position within the current word, saturating
  always_ff @(posedge ac_mclk or posedge reset) begin
    if (reset) begin
      bit_cnt_r <= CNT_WIDTH'(0);
    end else if (lr_edge_s) begin
      bit_cnt_r <= CNT_WIDTH'(0);
    end else if (bclk_rise_s && (bit_cnt_r != CNT_MAX)) begin
      bit_cnt_r <= bit_cnt_r + CNT_WIDTH'(1);
    end
  end

  // serial-to-parallel capture, restarted at every word boundary
  always_ff @(posedge ac_mclk or posedge reset) begin
    if (reset) begin
      shreg_r <= {SAMPLE_WIDTH{1'b0}};
    end else if (lr_edge_s) begin
      shreg_r <= {SAMPLE_WIDTH{1'b0}};
    end else if (shift_en_s) begin
      shreg_r <= {shreg_r[SAMPLE_WIDTH-2:0], sdata_s};
    end
  end

  // lrclk inactivity watchdog
  always_ff @(posedge ac_mclk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= TMO_WIDTH'(0);
    end else if (lr_edge_s || (state_r == WAIT_SYNC)) begin
      tmo_cnt_r <= TMO_WIDTH'(0);
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TMO_WIDTH'(1);
    end
  end

  // frame alignment FSM with registered frame, handshake, overrun and lock outputs
  always_ff @(posedge ac_mclk or posedge reset) begin
    if (reset) begin
      state_r       <= WAIT_SYNC;
      left_hold_r   <= {SAMPLE_WIDTH{1'b0}};
      frame_out_r   <= {FRAME_WIDTH{1'b0}};
      frame_valid_r <= 1'b0;
      overrun_r     <= 1'b0;
      locked_r      <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (frame_valid_r && bus.frame_ready) begin
        frame_valid_r <= 1'b0;
      end
      case (state_r)
        WAIT_SYNC: begin
          locked_r <= 1'b0;
          if (left_start_s) begin
            state_r <= LEFT;
          end
        end
        LEFT: begin
          if (timeout_s) begin
            state_r  <= WAIT_SYNC;
            locked_r <= 1'b0;
          end else if (right_start_s) begin
            left_hold_r <= word_s;
            state_r     <= RIGHT;
          end
        end
        RIGHT: begin
          if (timeout_s) begin
            state_r  <= WAIT_SYNC;
            locked_r <= 1'b0;
          end else if (left_start_s) begin
            // a completion in the consume cycle simply reloads; only an unconsumed frame overruns
            frame_out_r   <= {left_hold_r, word_s};
            frame_valid_r <= 1'b1;
            overrun_r     <= frame_valid_r && !bus.frame_ready;
            locked_r      <= 1'b1;
            state_r       <= LEFT;
          end
        end
        default: begin
          state_r  <= WAIT_SYNC;
          locked_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame_out   = frame_out_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.overrun     = overrun_r;
  assign bus.locked      = locked_r;

endmodule
